// File: rtl/openddr_pkg.sv
// Shared types for the openddr request path: queue entry layout and the
// row:bank:col address decode applied at enqueue.
package openddr_pkg;

    localparam int BANK_W = 3;
    localparam int ROW_W  = 16;
    localparam int COL_W  = 10;
    localparam int ID_W   = 4;
    localparam int ADDR_W = ROW_W + BANK_W + COL_W;

    typedef struct packed {
        logic              write;
        logic [ID_W-1:0]   id;
        logic [BANK_W-1:0] bank;
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
    } req_entry_t;

    localparam int ENTRY_W = $bits(req_entry_t);

    function automatic req_entry_t openddr_addr_decode(
        input logic [ADDR_W-1:0] addr,
        input logic              write,
        input logic [ID_W-1:0]   id
    );
        req_entry_t e;
        e.write = write;
        e.id    = id;
        e.row   = addr[ADDR_W-1 -: ROW_W];
        e.bank  = addr[COL_W +: BANK_W];
        e.col   = addr[COL_W-1:0];
        return e;
    endfunction

endpackage

// File: rtl/openddr_req_queue_if.sv
// Host-side and scheduler-side handshakes of the request queue, plus status.
// The queue uses the slave view; the host/scheduler pair uses master.
interface openddr_req_queue_if #(
    parameter int BANK_WIDTH = 3,
    parameter int ROW_WIDTH  = 16,
    parameter int COL_WIDTH  = 10,
    parameter int ID_WIDTH   = 4,
    parameter int DEPTH      = 8
);
    localparam int ADDR_WIDTH = ROW_WIDTH + BANK_WIDTH + COL_WIDTH;
    localparam int CNT_WIDTH  = $clog2(DEPTH + 1);

    logic                  host_valid;
    logic                  host_ready;
    logic [ADDR_WIDTH-1:0] host_addr;
    logic                  host_write;
    logic [ID_WIDTH-1:0]   host_id;
    logic                  flush;
    logic                  sched_valid;
    logic                  sched_ready;
    logic [BANK_WIDTH-1:0] sched_bank;
    logic [ROW_WIDTH-1:0]  sched_row;
    logic [COL_WIDTH-1:0]  sched_col;
    logic                  sched_write;
    logic [ID_WIDTH-1:0]   sched_id;
    logic [CNT_WIDTH-1:0]  q_count;
    logic                  q_almost_full;

    modport slave (
        input  host_valid, host_addr, host_write, host_id, flush, sched_ready,
        output host_ready, sched_valid, sched_bank, sched_row, sched_col,
        output sched_write, sched_id, q_count, q_almost_full
    );

    modport master (
        output host_valid, host_addr, host_write, host_id, flush, sched_ready,
        input  host_ready, sched_valid, sched_bank, sched_row, sched_col,
        input  sched_write, sched_id, q_count, q_almost_full
    );

endinterface

// File: rtl/openddr_sync_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with flush and a combinational head.
// Storage is deliberately left unreset; only pointers and count are cleared.
module openddr_sync_fifo #(
    parameter int DEPTH     = 8,
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 flush,
    input  logic [WIDTH-1:0]     wdata,
    output logic [WIDTH-1:0]     rdata,
    output logic [CNT_WIDTH-1:0] count,
    output logic [CNT_WIDTH-1:0] count_next
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_W-1:0]     wptr_q, wptr_d;
    logic [PTR_W-1:0]     rptr_q, rptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + PTR_W'(1);
            if (pop)  rptr_d = rptr_q + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_WIDTH'(1);
                2'b01:   count_d = count_q - CNT_WIDTH'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wptr_q] <= wdata;
    end

    assign rdata      = mem[rptr_q];
    assign count      = count_q;
    assign count_next = count_d;

endmodule

// File: rtl/openddr_req_queue.sv
// Host request queue ahead of openddr_scheduler: decode, FIFO, output gating.
// Define OPENDDR_REQ_BYPASS_EN for a zero-latency path when the queue is empty.
module openddr_req_queue
    import openddr_pkg::*;
#(
    parameter int BANK_WIDTH   = 3,
    parameter int ROW_WIDTH    = 16,
    parameter int COL_WIDTH    = 10,
    parameter int ID_WIDTH     = 4,
    parameter int DEPTH        = 8,
    parameter int AFULL_THRESH = 6
) (
    input  logic                clk,
    input  logic                rst,
    openddr_req_queue_if.slave  bus
);
    localparam int ADDR_WIDTH = ROW_WIDTH + BANK_WIDTH + COL_WIDTH;
    localparam int CNT_WIDTH  = $clog2(DEPTH + 1);

    logic [ADDR_WIDTH-1:0] host_addr;
    logic [CNT_WIDTH-1:0]  count;
    logic [CNT_WIDTH-1:0]  count_next;
    req_entry_t            dec_e;
    req_entry_t            head_e;
    req_entry_t            out_e;
    logic                  fifo_valid;
    logic                  host_ready;
    logic                  sched_valid;
    logic                  push;
    logic                  pop;
    logic                  afull_q, afull_d;
`ifdef OPENDDR_REQ_BYPASS_EN
    logic                  byp;
`endif

    assign host_addr = bus.host_addr;

    always_comb begin
        dec_e      = openddr_addr_decode(host_addr, bus.host_write, bus.host_id);
        fifo_valid = (count != '0) && !bus.flush;
        // Ready looks only at the registered count, so a full queue stays
        // closed even when the scheduler pops in the same cycle.
        host_ready = (count < CNT_WIDTH'(DEPTH)) && !bus.flush;
        pop        = fifo_valid && bus.sched_ready;
`ifdef OPENDDR_REQ_BYPASS_EN
        byp         = (count == '0) && bus.host_valid && !bus.flush;
        sched_valid = fifo_valid || byp;
        out_e       = byp ? dec_e : head_e;
        push        = bus.host_valid && host_ready && !(byp && bus.sched_ready);
`else
        sched_valid = fifo_valid;
        out_e       = head_e;
        push        = bus.host_valid && host_ready;
`endif
        afull_d    = count_next >= CNT_WIDTH'(AFULL_THRESH);
    end

    openddr_sync_fifo #(
        .DEPTH     (DEPTH),
        .WIDTH     (ENTRY_W),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .flush      (bus.flush),
        .wdata      (dec_e),
        .rdata      (head_e),
        .count      (count),
        .count_next (count_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) afull_q <= 1'b0;
        else     afull_q <= afull_d;
    end

    assign bus.host_ready    = host_ready;
    assign bus.sched_valid   = sched_valid;
    assign bus.sched_bank    = sched_valid ? BANK_WIDTH'(out_e.bank) : '0;
    assign bus.sched_row     = sched_valid ? ROW_WIDTH'(out_e.row)   : '0;
    assign bus.sched_col     = sched_valid ? COL_WIDTH'(out_e.col)   : '0;
    assign bus.sched_write   = sched_valid & out_e.write;
    assign bus.sched_id      = sched_valid ? ID_WIDTH'(out_e.id)     : '0;
    assign bus.q_count       = count;
    assign bus.q_almost_full = afull_q;

endmodule

// File: tb/tb_openddr_req_queue.sv
// Scoreboard bench for openddr_req_queue: accepted host requests are queued
// as expectations and checked in order against scheduler-side handshakes.
module tb_openddr_req_queue;

    typedef struct packed {
        logic        write;
        logic [3:0]  id;
        logic [2:0]  bank;
        logic [15:0] row;
        logic [9:0]  col;
    } exp_t;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;
    exp_t exp_q[$];

    openddr_req_queue_if bus ();

    openddr_req_queue dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard: record accepted requests, compare each scheduler pop.
    always @(negedge clk) begin
        exp_t e;
        exp_t got;
        if (!rst) begin
            if (bus.host_valid && bus.host_ready) begin
                e.write = bus.host_write;
                e.id    = bus.host_id;
                e.row   = bus.host_addr[28:13];
                e.bank  = bus.host_addr[12:10];
                e.col   = bus.host_addr[9:0];
                exp_q.push_back(e);
            end
            if (bus.sched_valid && bus.sched_ready) begin
                compared++;
                got = {bus.sched_write, bus.sched_id, bus.sched_bank,
                       bus.sched_row, bus.sched_col};
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL sb_pop got id=%0d but nothing was expected",
                             bus.sched_id);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        mismatched++;
                        $display("FAIL sb_entry got w=%0b id=%0d b=%0d r=%h c=%h exp w=%0b id=%0d b=%0d r=%h c=%h",
                                 got.write, got.id, got.bank, got.row, got.col,
                                 e.write, e.id, e.bank, e.row, e.col);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] row, input logic [2:0] bank,
                         input logic [9:0] col, input logic wr,
                         input logic [3:0] id);
        bus.host_valid = 1'b1;
        bus.host_addr  = {row, bank, col};
        bus.host_write = wr;
        bus.host_id    = id;
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.host_valid  = 1'b0;
        bus.sched_ready = 1'b1;
        while (bus.q_count != 0 && n < 50) begin
            step();
            n++;
        end
        bus.sched_ready = 1'b0;
        compared++;
        if (n >= 50) begin
            mismatched++;
            $display("FAIL drain_timeout count=%0d exp 0", bus.q_count);
        end
        @(negedge clk);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain_left got %0d pending exp 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        compared++;
        if ({bus.host_ready, bus.sched_valid, bus.q_count, bus.q_almost_full}
            !== {1'b1, 1'b0, 4'd0, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_ctl got rdy=%0b vld=%0b cnt=%0d af=%0b exp 1 0 0 0",
                     bus.host_ready, bus.sched_valid, bus.q_count, bus.q_almost_full);
        end
        compared++;
        if ({bus.sched_bank, bus.sched_row, bus.sched_col, bus.sched_write,
             bus.sched_id} !== '0) begin
            mismatched++;
            $display("FAIL reset_data got nonzero sched data exp 0");
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_single_push();
        drive(16'h1234, 3'd5, 10'h02A, 1'b1, 4'd3);
        @(negedge clk);
        compared++;
`ifdef OPENDDR_REQ_BYPASS_EN
        if (bus.sched_valid !== 1'b1) begin
`else
        if (bus.sched_valid !== 1'b0) begin
`endif
            mismatched++;
            $display("FAIL single_pre_vld got %0b", bus.sched_valid);
        end
        step();
        bus.host_valid = 1'b0;
        @(negedge clk);
        compared++;
        if ({bus.sched_valid, bus.sched_bank, bus.sched_row, bus.sched_col,
             bus.sched_write, bus.sched_id}
            !== {1'b1, 3'd5, 16'h1234, 10'h02A, 1'b1, 4'd3}) begin
            mismatched++;
            $display("FAIL single_head got v=%0b b=%0d r=%h c=%h w=%0b id=%0d exp 1 5 1234 02a 1 3",
                     bus.sched_valid, bus.sched_bank, bus.sched_row,
                     bus.sched_col, bus.sched_write, bus.sched_id);
        end
        compared++;
        if (bus.q_count !== 4'd1) begin
            mismatched++;
            $display("FAIL single_cnt got %0d exp 1", bus.q_count);
        end
        step();
        drain();
    endtask

    task automatic test_fill();
        for (int k = 1; k <= 8; k++) begin
            drive(16'(k * 16'h0101), 3'(k), 10'(k * 3), k[0], 4'(k - 1));
            step();
            bus.host_valid = 1'b0;
            @(negedge clk);
            compared++;
            if (bus.q_count !== 4'(k) || bus.q_almost_full !== (k >= 6) ||
                bus.host_ready !== (k < 8)) begin
                mismatched++;
                $display("FAIL fill_%0d got cnt=%0d af=%0b rdy=%0b exp cnt=%0d af=%0b rdy=%0b",
                         k, bus.q_count, bus.q_almost_full, bus.host_ready,
                         k, (k >= 6), (k < 8));
            end
            step();
        end
        drive(16'hBEEF, 3'd7, 10'h3FF, 1'b0, 4'd8);
        bus.sched_ready = 1'b1;
        @(negedge clk);
        compared++;
        if (bus.host_ready !== 1'b0 || bus.sched_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL full_pop_rdy got rdy=%0b vld=%0b exp rdy=0 vld=1",
                     bus.host_ready, bus.sched_valid);
        end
        step();
        bus.sched_ready = 1'b0;
        @(negedge clk);
        compared++;
        if (bus.q_count !== 4'd7 || bus.host_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL after_pop got cnt=%0d rdy=%0b exp cnt=7 rdy=1",
                     bus.q_count, bus.host_ready);
        end
        step();
        bus.host_valid = 1'b0;
        @(negedge clk);
        compared++;
        if (bus.q_count !== 4'd8) begin
            mismatched++;
            $display("FAIL ninth_in got cnt=%0d exp 8", bus.q_count);
        end
        step();
        drain();
    endtask

    task automatic test_back_to_back();
        drive(16'h0100, 3'd1, 10'd0, 1'b0, 4'd0);
        step();
        drive(16'h0101, 3'd2, 10'd1, 1'b1, 4'd1);
        step();
        bus.sched_ready = 1'b1;
        for (int i = 2; i < 20; i++) begin
            drive(16'(16'h0100 + i), 3'(i), 10'(i), i[0], 4'(i));
            @(negedge clk);
            compared++;
            if (bus.q_count !== 4'd2) begin
                mismatched++;
                $display("FAIL stream_cnt_%0d got %0d exp 2", i, bus.q_count);
            end
            step();
        end
        drain();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            drive(16'h2000 + 16'(i), 3'(i), 10'(i + 100), 1'b1, 4'(i));
            step();
        end
        drive(16'h3333, 3'd3, 10'd3, 1'b0, 4'd9);
        bus.sched_ready = 1'b1;
        bus.flush       = 1'b1;
        @(negedge clk);
        compared++;
        if (bus.host_ready !== 1'b0 || bus.sched_valid !== 1'b0 ||
            bus.q_count !== 4'd5) begin
            mismatched++;
            $display("FAIL flush_cycle got rdy=%0b vld=%0b cnt=%0d exp 0 0 5",
                     bus.host_ready, bus.sched_valid, bus.q_count);
        end
        step();
        bus.flush       = 1'b0;
        bus.host_valid  = 1'b0;
        bus.sched_ready = 1'b0;
        exp_q.delete();
        @(negedge clk);
        compared++;
        if (bus.q_count !== 4'd0 || bus.sched_valid !== 1'b0 ||
            bus.host_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL flush_after got cnt=%0d vld=%0b rdy=%0b exp 0 0 1",
                     bus.q_count, bus.sched_valid, bus.host_ready);
        end
        step();
    endtask

    task automatic test_bypass();
        drive(16'hCAFE, 3'd6, 10'h155, 1'b1, 4'd12);
        bus.sched_ready = 1'b1;
        @(negedge clk);
        compared++;
`ifdef OPENDDR_REQ_BYPASS_EN
        if (bus.sched_valid !== 1'b1 || bus.sched_id !== 4'd12) begin
`else
        if (bus.sched_valid !== 1'b0) begin
`endif
            mismatched++;
            $display("FAIL byp_same got vld=%0b id=%0d", bus.sched_valid,
                     bus.sched_id);
        end
        step();
        bus.host_valid = 1'b0;
        @(negedge clk);
        compared++;
`ifdef OPENDDR_REQ_BYPASS_EN
        if (bus.q_count !== 4'd0 || bus.sched_valid !== 1'b0) begin
`else
        if (bus.q_count !== 4'd1 || bus.sched_valid !== 1'b1) begin
`endif
            mismatched++;
            $display("FAIL byp_next got cnt=%0d vld=%0b", bus.q_count,
                     bus.sched_valid);
        end
        step();
        drain();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            drive(16'h4000 + 16'(i), 3'(i + 2), 10'(i + 7), 1'b0, 4'(i + 4));
            step();
        end
        bus.host_valid = 1'b0;
        @(negedge clk);
        compared++;
        if (bus.q_count !== 4'd3) begin
            mismatched++;
            $display("FAIL ar_pre got cnt=%0d exp 3", bus.q_count);
        end
        #2;
        rst = 1'b1;
        #1;
        compared++;
        if (bus.sched_valid !== 1'b0 || bus.q_count !== 4'd0 ||
            bus.host_ready !== 1'b1 || bus.sched_id !== 4'd0) begin
            mismatched++;
            $display("FAIL ar_async got vld=%0b cnt=%0d rdy=%0b id=%0d exp 0 0 1 0",
                     bus.sched_valid, bus.q_count, bus.host_ready, bus.sched_id);
        end
        exp_q.delete();
        step();
        rst = 1'b0;
        drive(16'hA5A5, 3'd4, 10'h0F0, 1'b1, 4'd10);
        step();
        bus.host_valid = 1'b0;
        @(negedge clk);
        compared++;
        if ({bus.sched_valid, bus.sched_bank, bus.sched_row, bus.sched_col,
             bus.sched_write, bus.sched_id}
            !== {1'b1, 3'd4, 16'hA5A5, 10'h0F0, 1'b1, 4'd10}) begin
            mismatched++;
            $display("FAIL ar_post got v=%0b b=%0d r=%h c=%h w=%0b id=%0d exp 1 4 a5a5 0f0 1 10",
                     bus.sched_valid, bus.sched_bank, bus.sched_row,
                     bus.sched_col, bus.sched_write, bus.sched_id);
        end
        step();
        drain();
    endtask

    initial begin
        compared        = 0;
        mismatched      = 0;
        rst             = 1'b1;
        bus.host_valid  = 1'b0;
        bus.host_addr   = '0;
        bus.host_write  = 1'b0;
        bus.host_id     = '0;
        bus.flush       = 1'b0;
        bus.sched_ready = 1'b0;
        test_reset();
        test_single_push();
        test_fill();
        test_back_to_back();
        test_flush();
        test_bypass();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
